raiz_alu: RTL and testbench
===========================

Name: raiz_alu

Overview:
- Multi-cycle arithmetic unit that executes the operations sequenced by the square-root (Newton iteration) controller: add, subtract, halve, and fixed-point divide.
- Operands arrive from the operand input mux. Results go back to the X/Y/C/Z/D register bank.
- Handshake with the controller: START in; level DONE out, held until consumed. DONE is the controller's ALUDONE input.

Parameters:
- WIDTH, 16, operand/result width in bits (unsigned).
- FRAC, 8, fractional bits of the fixed-point format; used only by DIV.

Ports:
- CLK    input   1      clock, rising edge
- RST    input   1      reset, asynchronous, active-high
- ALURST input   1      synchronous clear from controller
- START  input   1      operation request, sampled in IDLE only
- OP     input   2      00 ADD, 01 SUB, 10 HALF, 11 DIV
- A      input   WIDTH  operand A
- B      input   WIDTH  operand B
- RESULT output  WIDTH  registered result
- DONE   output  1      result valid; level, sticky
- BUSY   output  1      operation in progress
- DIVZ   output  1      divide-by-zero flag (see Optional Feature)

Behaviour:
- Reset: RST asynchronously forces state IDLE, RESULT=0, DONE=0, BUSY=0, DIVZ=0, internal regs 0.
- ALURST: synchronous, same effect as RST at the next edge. Priority over START. Aborts any operation in progress.
- States:
  - IDLE: START=1 captures A, B, OP at edge 0; clears DONE and DIVZ; BUSY=1. OP 00/01/10 go to EXEC; OP 11 goes to DIV.
  - EXEC: at edge 1, RESULT is written, DONE=1, BUSY=0, return to IDLE.
  - DIV: restoring shift-subtract, one quotient bit per cycle, N=WIDTH+FRAC iterations. At edge N, RESULT is written, DONE=1, BUSY=0, return to IDLE.
  - FIN: no separate FIN state.
- Latency, counted from the START-capture edge: ADD/SUB/HALF take 1 cycle; DIV takes N cycles (24 at defaults).
- Arithmetic:
  - ADD: (A+B) mod 2^WIDTH; carry discarded.
  - SUB: (A-B) mod 2^WIDTH; borrow discarded.
  - HALF: A>>1, logical; B ignored.
  - DIV: low WIDTH bits of floor((A<<FRAC)/B), with unsigned (WIDTH+FRAC)-bit dividend. Operands are latched at START, so A/B may change during DIV without effect.
- DONE handshake:
  - DONE stays 1 until the next accepted START, ALURST, or RST. The controller may sample it any number of cycles later.
  - DONE falls at the same edge that captures START. The controller's wait state therefore never sees a stale DONE.
- START while BUSY=1 is ignored: no restart, no captured operands.
- START and DONE=1 in IDLE: accepted normally; DONE clears at that edge.
- RESULT holds its last value between operations. It changes only at completion, ALURST, or RST.
- Iteration counter: width clog2(N+1). It cannot wrap.

Optional Feature:
- Macro: RAIZ_ALU_DIVZERO_EN
- Defined: DIV with captured B==0 skips iteration. At edge 1, RESULT={WIDTH{1}}, DIVZ=1, DONE=1. DIVZ clears on next accepted START, ALURST, or RST.
- Undefined: DIVZ tied 0. DIV with B==0 runs the full N cycles; the restoring algorithm yields RESULT={WIDTH{1}}.

Test Plan:
- Assert RST mid-cycle with random inputs -> immediately RESULT=0x0000, DONE=0, BUSY=0, DIVZ=0; the first START after release is accepted.
- ADD A=0x1234 B=0x0F0F START 1 cycle -> at edge 1 RESULT=0x2143, DONE=1. DONE stays 1 for 5 idle cycles, then clears on the edge capturing the next START.
- SUB A=0x0005 B=0x0007 -> RESULT=0xFFFE after 1 cycle. Then HALF A=0x8001 -> RESULT=0x4000.
- DIV A=0x0300 B=0x0200 (3.0/2.0, Q8.8) -> BUSY=1 for exactly 24 cycles; RESULT=0x0180 and DONE=1 at edge 24. A START pulsed at cycle 5 is ignored, and changing A/B mid-operation has no effect.
- DIV A=0x0100 B=0x0003, ALURST at cycle 10 -> next edge IDLE, RESULT=0, DONE=0, BUSY=0. ALURST and START asserted together -> START ignored.
- DIV A=0x1234 B=0x0000:
  - With RAIZ_ALU_DIVZERO_EN: RESULT=0xFFFF, DIVZ=1, DONE at edge 1.
  - Without: RESULT=0xFFFF, DIVZ=0, DONE at edge 24.

Source files
------------

// File: rtl/raiz_alu.sv
// rtl/raiz_alu.sv - multi-cycle add/sub/halve/fixed-point-divide unit for the Newton square-root controller
// Optional: RAIZ_ALU_DIVZERO_EN enables the divide-by-zero shortcut and the DIVZ flag.
module raiz_alu #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ALURST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic             DONE,
    output logic             BUSY,
    output logic             DIVZ
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_HALF = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
`ifdef RAIZ_ALU_DIVZERO_EN
    logic             divz_q, divz_d;
`endif

    // One restoring step: the dividend register shifts out its MSB into the
    // remainder and shifts the new quotient bit in at the bottom.
    logic [WIDTH:0]   rem_shift;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [N-1:0]     dvd_next;

    always_comb begin
        rem_shift = {rem_q, dvd_q[N-1]};
        q_bit     = (rem_shift >= {1'b0, b_q});
        rem_next  = q_bit ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
        dvd_next  = {dvd_q[N-2:0], q_bit};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
`ifdef RAIZ_ALU_DIVZERO_EN
        divz_d   = divz_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    op_d   = OP;
                    a_d    = A;
                    b_d    = B;
                    dvd_d  = {A, {FRAC{1'b0}}};
                    rem_d  = '0;
                    cnt_d  = '0;
                    done_d = 1'b0;
                    state_d = (OP == OP_DIV) ? DIV : EXEC;
`ifdef RAIZ_ALU_DIVZERO_EN
                    divz_d = 1'b0;
                    if (OP == OP_DIV && B == '0) begin
                        state_d = EXEC;
                    end
`endif
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD:  result_d = a_q + b_q;
                    OP_SUB:  result_d = a_q - b_q;
                    OP_HALF: result_d = {1'b0, a_q[WIDTH-1:1]};
                    default: begin
                        // Only reached by a zero-divisor DIV when the shortcut is enabled.
                        result_d = '1;
`ifdef RAIZ_ALU_DIVZERO_EN
                        divz_d   = 1'b1;
`endif
                    end
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DIV: begin
                dvd_d = dvd_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = dvd_next[WIDTH-1:0];
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ALURST) begin
            state_d  = IDLE;
            op_d     = '0;
            a_d      = '0;
            b_d      = '0;
            dvd_d    = '0;
            rem_d    = '0;
            cnt_d    = '0;
            result_d = '0;
            done_d   = 1'b0;
`ifdef RAIZ_ALU_DIVZERO_EN
            divz_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef RAIZ_ALU_DIVZERO_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            divz_q <= 1'b0;
        end else begin
            divz_q <= divz_d;
        end
    end
    assign DIVZ = divz_q;
`else
    assign DIVZ = 1'b0;
`endif

    assign RESULT = result_q;
    assign DONE   = done_q;
    assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_raiz_alu.sv
// tb/tb_raiz_alu.sv - scoreboard bench for raiz_alu
module tb_raiz_alu;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ALURST = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] RESULT;
    logic        DONE;
    logic        BUSY;
    logic        DIVZ;

    raiz_alu #(.WIDTH(16), .FRAC(8)) dut (
        .CLK(CLK), .RST(RST), .ALURST(ALURST), .START(START), .OP(OP),
        .A(A), .B(B), .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY), .DIVZ(DIVZ)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_res_q[$];
    int          exp_lat_q[$];
    logic        exp_divz_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

`ifdef RAIZ_ALU_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    function automatic logic [15:0] model_res(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [23:0] q;
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: return a >> 1;
            default: begin
                if (b == 16'h0) return 16'hFFFF;
                q = {a, 8'h00} / {8'h00, b};
                return q[15:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [15:0] b);
        if (op != 2'b11) return 1;
        if (DZ_EN && b == 16'h0) return 1;
        return 24;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input bit track);
        @(negedge CLK);
        OP = op; A = a; B = b; START = 1'b1;
        if (track) begin
            exp_res_q.push_back(model_res(op, a, b));
            exp_lat_q.push_back(model_lat(op, b));
            exp_divz_q.push_back(DZ_EN && op == 2'b11 && b == 16'h0);
        end
        @(posedge CLK);
        #1;
        START = 1'b0;
        check("done_clr_at_start", DONE, 0);
        check("busy_at_start", BUSY, 1);
    endtask

    task automatic finish_op(input bit disturb);
        int cyc = 0;
        while (DONE !== 1'b1 && cyc < 100) begin
            if (disturb) begin
                check("busy_during_div", BUSY, 1);
                if (cyc == 4) begin
                    START = 1'b1; OP = 2'b00;
                    A = 16'($urandom); B = 16'($urandom);
                end
                if (cyc == 5) START = 1'b0;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("latency", cyc, exp_lat_q.pop_front());
        check("result", RESULT, exp_res_q.pop_front());
        check("divz", DIVZ, exp_divz_q.pop_front());
        check("busy_clr_at_done", BUSY, 0);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        check("rst_result", RESULT, 0);
        check("rst_done", DONE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_divz", DIVZ, 0);
        @(negedge CLK);
        RST = 1'b0;

        issue(2'b00, 16'h1234, 16'h0F0F, 1'b1);
        finish_op(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check("done_sticky", DONE, 1);
        end

        issue(2'b01, 16'h0005, 16'h0007, 1'b1);
        finish_op(1'b0);
        issue(2'b10, 16'h8001, 16'h5555, 1'b1);
        finish_op(1'b0);

        issue(2'b11, 16'h0300, 16'h0200, 1'b1);
        finish_op(1'b1);

        issue(2'b11, 16'h0100, 16'h0003, 1'b0);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        ALURST = 1'b1; START = 1'b1; OP = 2'b00; A = 16'h0001; B = 16'h0001;
        @(posedge CLK);
        #1;
        ALURST = 1'b0; START = 1'b0;
        check("alurst_result", RESULT, 0);
        check("alurst_done", DONE, 0);
        check("alurst_busy", BUSY, 0);
        @(posedge CLK);
        #1;
        check("alurst_start_ignored_done", DONE, 0);
        check("alurst_start_ignored_busy", BUSY, 0);

        issue(2'b11, 16'h1234, 16'h0000, 1'b1);
        finish_op(1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [1:0]  rop;
            logic [15:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = (i == 7) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
            issue(rop, ra, rb, 1'b1);
            finish_op(1'b0);
        end

        issue(2'b00, 16'h4000, 16'h0123, 1'b1);
        finish_op(1'b0);
        issue(2'b11, 16'($urandom), 16'h0007, 1'b0);
        repeat (3) @(posedge CLK);
        #3;
        A = 16'($urandom); B = 16'($urandom); OP = 2'($urandom); START = 1'($urandom);
        RST = 1'b1;
        #1;
        check("async_rst_result", RESULT, 0);
        check("async_rst_done", DONE, 0);
        check("async_rst_busy", BUSY, 0);
        check("async_rst_divz", DIVZ, 0);
        @(negedge CLK);
        START = 1'b0;
        RST = 1'b0;
        issue(2'b00, 16'h0001, 16'h0002, 1'b1);
        finish_op(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
